// File: rtl/wm_phase_timer_pkg.sv
// Shared washing-machine controller definitions: state codes, phase indices,
// timer FSM encoding and the power-on phase durations.
package wm_phase_timer_pkg;

    localparam int PHASE_COUNT = 5;
    localparam int CNT_W       = 8;

    localparam logic [2:0] STATE_FILL_WATER = 3'd2;
    localparam logic [2:0] STATE_HEAT_WATER = 3'd3;
    localparam logic [2:0] STATE_WASH       = 3'd4;
    localparam logic [2:0] STATE_RINSE      = 3'd5;
    localparam logic [2:0] STATE_SPIN       = 3'd6;

    typedef enum logic [2:0] {
        PH_FILL  = 3'd0,
        PH_HEAT  = 3'd1,
        PH_WASH  = 3'd2,
        PH_RINSE = 3'd3,
        PH_SPIN  = 3'd4
    } phase_e;

    typedef enum logic [1:0] {
        TMR_IDLE = 2'd0,
        TMR_RUN  = 2'd1,
        TMR_HOLD = 2'd2,
        TMR_DONE = 2'd3
    } tmr_state_e;

    localparam logic [CNT_W-1:0] DUR_FILL  = 8'd3;
    localparam logic [CNT_W-1:0] DUR_HEAT  = 8'd3;
    localparam logic [CNT_W-1:0] DUR_WASH  = 8'd5;
    localparam logic [CNT_W-1:0] DUR_RINSE = 8'd3;
    localparam logic [CNT_W-1:0] DUR_SPIN  = 8'd2;

    // Phase 0 occupies the least-significant field.
    localparam logic [PHASE_COUNT*CNT_W-1:0] DEFAULT_DURATIONS_PKD =
        {DUR_SPIN, DUR_RINSE, DUR_WASH, DUR_HEAT, DUR_FILL};

endpackage

// File: rtl/wm_phase_timer_duration_regs.sv
// Per-phase duration register file with reset defaults, one write port and a
// combinational read that already reflects a write sampled on this edge.
module wm_duration_regs #(
    parameter int NUM_PHASES = 5,
    parameter int CNT_WIDTH  = 8,
    parameter int PHASE_W    = 3,
    parameter logic [NUM_PHASES*CNT_WIDTH-1:0] DEFAULT_DURATIONS = '0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 load_en,
    input  logic [PHASE_W-1:0]   load_phase,
    input  logic [CNT_WIDTH-1:0] load_value,
    input  logic [PHASE_W-1:0]   rd_phase,
    output logic [CNT_WIDTH-1:0] rd_data
);

    logic [CNT_WIDTH-1:0] dur_q [NUM_PHASES];
    logic [CNT_WIDTH-1:0] dur_d [NUM_PHASES];

    always_comb begin
        // NOTE: every combinationally written variable gets a default first so no latch is inferred.
        dur_d = dur_q;
        if (load_en && (int'(load_phase) < NUM_PHASES)) begin
            dur_d[load_phase] = load_value;
        end
    end

    // Reading the post-write value lets a load to the running phase act at once.
    always_comb begin
        rd_data = '0;
        if (int'(rd_phase) < NUM_PHASES) begin
            rd_data = dur_d[rd_phase];
        end
    end

    // NOTE: this storage is reset on purpose -- the durations must come up at their defaults, so it maps to flops, not RAM.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_PHASES; i++) begin
                dur_q[i] <= DEFAULT_DURATIONS[i*CNT_WIDTH +: CNT_WIDTH];
            end
        end else begin
            dur_q <= dur_d;
        end
    end

endmodule

// File: rtl/wm_phase_timer.sv
// Phase timer beside the washing-machine controller FSM: times the active
// phase against its programmable duration and raises the completion signals.
module wm_phase_timer
    import wm_phase_timer_pkg::*;
#(
    parameter int NUM_PHASES        = PHASE_COUNT,
    parameter int STATE_WIDTH       = 3,
    parameter int FIRST_PHASE_STATE = int'(STATE_FILL_WATER),
    parameter int CNT_WIDTH         = CNT_W,
    parameter logic [NUM_PHASES*CNT_WIDTH-1:0] DEFAULT_DURATIONS = DEFAULT_DURATIONS_PKD,
    localparam int PHASE_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [STATE_WIDTH-1:0] state,
    input  logic                   pause,
    input  logic                   load_en,
    input  logic [PHASE_W-1:0]     load_phase,
    input  logic [CNT_WIDTH-1:0]   load_value,
    output logic                   sig_Full,
    output logic                   sig_Temperature,
    output logic                   sig_Completed,
    output logic [NUM_PHASES-1:0]  phase_done,
    output logic [CNT_WIDTH-1:0]   remaining,
    output logic                   active
);

    logic                 phase_valid;
    logic [PHASE_W-1:0]   cur_phase;
    logic [CNT_WIDTH-1:0] dur_rd;
    logic [CNT_WIDTH-1:0] dur_eff;

    tmr_state_e           tmr_q, tmr_d;
    logic [PHASE_W-1:0]   phase_q, phase_d;
    logic [CNT_WIDTH-1:0] elapsed_q, elapsed_d;
    logic [CNT_WIDTH-1:0] remaining_q, remaining_d;
    logic [NUM_PHASES-1:0] phase_done_q, phase_done_d;
    logic                 sig_full_q, sig_full_d;
    logic                 sig_temp_q, sig_temp_d;
    logic                 sig_comp_q, sig_comp_d;
    logic                 active_q, active_d;
    logic                 new_entry;
    logic                 done_pulse;

    always_comb begin
        phase_valid = 1'b0;
        cur_phase   = '0;
        if ((int'(state) >= FIRST_PHASE_STATE) &&
            (int'(state) <  FIRST_PHASE_STATE + NUM_PHASES)) begin
            phase_valid = 1'b1;
            cur_phase   = PHASE_W'(int'(state) - FIRST_PHASE_STATE);
        end
    end

    wm_duration_regs #(
        .NUM_PHASES       (NUM_PHASES),
        .CNT_WIDTH        (CNT_WIDTH),
        .PHASE_W          (PHASE_W),
        .DEFAULT_DURATIONS(DEFAULT_DURATIONS)
    ) u_duration_regs (
        .clock     (clock),
        .reset     (reset),
        .load_en   (load_en),
        .load_phase(load_phase),
        .load_value(load_value),
        .rd_phase  (cur_phase),
        .rd_data   (dur_rd)
    );

    // A zero duration would otherwise never complete.
    assign dur_eff = (dur_rd == '0) ? CNT_WIDTH'(1) : dur_rd;

    always_comb begin
        tmr_d      = tmr_q;
        phase_d    = phase_q;
        elapsed_d  = elapsed_q;
        done_pulse = 1'b0;
        new_entry  = phase_valid && ((tmr_q == TMR_IDLE) || (cur_phase != phase_q));

        if (!phase_valid) begin
            tmr_d     = TMR_IDLE;
            phase_d   = '0;
            elapsed_d = '0;
        end else if (new_entry) begin
            phase_d = cur_phase;
            if (pause) begin
                tmr_d     = TMR_HOLD;
                elapsed_d = '0;
            end else begin
                elapsed_d = CNT_WIDTH'(1);
                if (dur_eff == CNT_WIDTH'(1)) begin
                    tmr_d      = TMR_DONE;
                    done_pulse = 1'b1;
                end else begin
                    tmr_d = TMR_RUN;
                end
            end
        end else if (tmr_q == TMR_DONE) begin
            tmr_d = TMR_DONE;
        end else if (pause) begin
            tmr_d = TMR_HOLD;
        end else begin
            // A shortened duration can leave elapsed past it; clamp rather than wrap.
            if (elapsed_q >= dur_eff - CNT_WIDTH'(1)) begin
                elapsed_d  = dur_eff;
                tmr_d      = TMR_DONE;
                done_pulse = 1'b1;
            end else begin
                elapsed_d = elapsed_q + CNT_WIDTH'(1);
                tmr_d     = TMR_RUN;
            end
        end
    end

    always_comb begin
        sig_full_d   = (tmr_d == TMR_DONE) && (int'(phase_d) == int'(PH_FILL));
        sig_temp_d   = (tmr_d == TMR_DONE) && (int'(phase_d) == int'(PH_HEAT));
        sig_comp_d   = (tmr_d == TMR_DONE) && (int'(phase_d) >= int'(PH_WASH));
        active_d     = (tmr_d == TMR_RUN);
        phase_done_d = '0;
        if (done_pulse) begin
            phase_done_d[phase_d] = 1'b1;
        end
        remaining_d = '0;
        if (((tmr_d == TMR_RUN) || (tmr_d == TMR_HOLD)) && (dur_eff > elapsed_d)) begin
            remaining_d = dur_eff - elapsed_d;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            tmr_q        <= TMR_IDLE;
            phase_q      <= '0;
            elapsed_q    <= '0;
            remaining_q  <= '0;
            phase_done_q <= '0;
            sig_full_q   <= 1'b0;
            sig_temp_q   <= 1'b0;
            sig_comp_q   <= 1'b0;
            active_q     <= 1'b0;
        end else begin
            tmr_q        <= tmr_d;
            phase_q      <= phase_d;
            elapsed_q    <= elapsed_d;
            remaining_q  <= remaining_d;
            phase_done_q <= phase_done_d;
            sig_full_q   <= sig_full_d;
            sig_temp_q   <= sig_temp_d;
            sig_comp_q   <= sig_comp_d;
            active_q     <= active_d;
        end
    end

    assign sig_Full        = sig_full_q;
    assign sig_Temperature = sig_temp_q;
    assign sig_Completed   = sig_comp_q;
    assign phase_done      = phase_done_q;
    assign remaining       = remaining_q;
    assign active          = active_q;

endmodule

// File: tb/tb_wm_phase_timer.sv
// Directed bench for wm_phase_timer: a vector table for the basic phase flows
// plus hand-written sequences for loads, phase switches and reset.
module tb_wm_phase_timer;

    logic       clock;
    logic       reset;
    logic [2:0] state;
    logic       pause;
    logic       load_en;
    logic [2:0] load_phase;
    logic [7:0] load_value;
    logic       sig_Full;
    logic       sig_Temperature;
    logic       sig_Completed;
    logic [4:0] phase_done;
    logic [7:0] remaining;
    logic       active;

    int n_tests = 0;
    int n_fail  = 0;

    wm_phase_timer dut (
        .clock          (clock),
        .reset          (reset),
        .state          (state),
        .pause          (pause),
        .load_en        (load_en),
        .load_phase     (load_phase),
        .load_value     (load_value),
        .sig_Full       (sig_Full),
        .sig_Temperature(sig_Temperature),
        .sig_Completed  (sig_Completed),
        .phase_done     (phase_done),
        .remaining      (remaining),
        .active         (active)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       rst;
        logic [2:0] st;
        logic       pz;
        logic       full;
        logic       temp;
        logic       comp;
        logic [4:0] pd;
        logic [7:0] rem;
        logic       act;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_vec(input logic rst, input logic [2:0] st, input logic pz,
                                    input logic full, input logic temp, input logic comp,
                                    input logic [4:0] pd, input logic [7:0] rem, input logic act);
        vec_t v;
        v.rst = rst; v.st = st; v.pz = pz;
        v.full = full; v.temp = temp; v.comp = comp;
        v.pd = pd; v.rem = rem; v.act = act;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic full, input logic temp, input logic comp,
                         input logic [4:0] pd, input logic [7:0] rem, input logic act);
        logic [16:0] got, exp;
        got = {sig_Full, sig_Temperature, sig_Completed, phase_done, remaining, active};
        exp = {full, temp, comp, pd, rem, act};
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got full=%b temp=%b comp=%b pd=%b rem=%0d act=%b, want full=%b temp=%b comp=%b pd=%b rem=%0d act=%b",
                     name, sig_Full, sig_Temperature, sig_Completed, phase_done, remaining, active,
                     full, temp, comp, pd, rem, act);
        end
    endtask

    task automatic drive(input logic rst, input logic [2:0] st, input logic pz,
                         input logic ld, input logic [2:0] lp, input logic [7:0] lv);
        reset = rst; state = st; pause = pz;
        load_en = ld; load_phase = lp; load_value = lv;
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        drive(1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 8'd0);

        // Fill (D=3), wash with pause on phase edges 2-4, entry with pause.
        add_vec(1, 0, 0,  0, 0, 0, 5'b00000, 0, 0);
        add_vec(0, 2, 0,  0, 0, 0, 5'b00000, 2, 1);
        add_vec(0, 2, 0,  0, 0, 0, 5'b00000, 1, 1);
        add_vec(0, 2, 0,  1, 0, 0, 5'b00001, 0, 0);
        add_vec(0, 2, 0,  1, 0, 0, 5'b00000, 0, 0);
        add_vec(0, 0, 0,  0, 0, 0, 5'b00000, 0, 0);
        add_vec(0, 4, 0,  0, 0, 0, 5'b00000, 4, 1);
        add_vec(0, 4, 1,  0, 0, 0, 5'b00000, 4, 0);
        add_vec(0, 4, 1,  0, 0, 0, 5'b00000, 4, 0);
        add_vec(0, 4, 1,  0, 0, 0, 5'b00000, 4, 0);
        add_vec(0, 4, 0,  0, 0, 0, 5'b00000, 3, 1);
        add_vec(0, 4, 0,  0, 0, 0, 5'b00000, 2, 1);
        add_vec(0, 4, 0,  0, 0, 0, 5'b00000, 1, 1);
        add_vec(0, 4, 0,  0, 0, 1, 5'b00100, 0, 0);
        add_vec(0, 4, 0,  0, 0, 1, 5'b00000, 0, 0);
        add_vec(0, 1, 0,  0, 0, 0, 5'b00000, 0, 0);
        add_vec(0, 3, 0,  0, 0, 0, 5'b00000, 2, 1);
        add_vec(0, 3, 0,  0, 0, 0, 5'b00000, 1, 1);
        add_vec(0, 3, 0,  0, 1, 0, 5'b00010, 0, 0);
        add_vec(0, 2, 1,  0, 0, 0, 5'b00000, 3, 0);
        add_vec(0, 2, 0,  0, 0, 0, 5'b00000, 2, 1);
        add_vec(0, 0, 0,  0, 0, 0, 5'b00000, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].st, vecs[i].pz, 1'b0, 3'd0, 8'd0);
            cyc();
            check($sformatf("vec%0d", i), vecs[i].full, vecs[i].temp, vecs[i].comp,
                  vecs[i].pd, vecs[i].rem, vecs[i].act);
        end

        // Shorten wash to 2 while elapsed=3: completes on the load edge, single pulse.
        drive(0, 4, 0, 0, 0, 0); cyc(); check("ld_e1", 0, 0, 0, 5'b00000, 4, 1);
        cyc();                          check("ld_e2", 0, 0, 0, 5'b00000, 3, 1);
        cyc();                          check("ld_e3", 0, 0, 0, 5'b00000, 2, 1);
        drive(0, 4, 0, 1, 2, 2); cyc(); check("ld_done", 0, 0, 1, 5'b00100, 0, 0);
        drive(0, 4, 0, 0, 0, 0); cyc(); check("ld_hold1", 0, 0, 1, 5'b00000, 0, 0);
        cyc();                          check("ld_hold2", 0, 0, 1, 5'b00000, 0, 0);
        drive(0, 0, 0, 0, 0, 0); cyc(); check("ld_idle", 0, 0, 0, 5'b00000, 0, 0);

        // Wash mid-count, then rinse: restart at 1, no wash pulse.
        drive(0, 4, 0, 0, 0, 0); cyc(); check("sw_wash", 0, 0, 0, 5'b00000, 1, 1);
        drive(0, 5, 0, 0, 0, 0); cyc(); check("sw_r1", 0, 0, 0, 5'b00000, 2, 1);
        cyc();                          check("sw_r2", 0, 0, 0, 5'b00000, 1, 1);
        cyc();                          check("sw_r3", 0, 0, 1, 5'b01000, 0, 0);
        drive(0, 0, 0, 0, 0, 0); cyc(); check("sw_idle", 0, 0, 0, 5'b00000, 0, 0);

        // Spin duration 0 behaves as 1; out-of-range load indices are ignored.
        drive(0, 0, 0, 1, 4, 0); cyc(); check("z_load", 0, 0, 0, 5'b00000, 0, 0);
        drive(0, 6, 0, 0, 0, 0); cyc(); check("z_spin", 0, 0, 1, 5'b10000, 0, 0);
        drive(0, 0, 0, 1, 7, 9); cyc(); check("bad7", 0, 0, 0, 5'b00000, 0, 0);
        drive(0, 0, 0, 1, 5, 9); cyc(); check("bad5", 0, 0, 0, 5'b00000, 0, 0);
        drive(0, 2, 0, 0, 0, 0); cyc(); check("keep_fill", 0, 0, 0, 5'b00000, 2, 1);
        drive(0, 3, 0, 0, 0, 0); cyc(); check("keep_heat", 0, 0, 0, 5'b00000, 2, 1);
        drive(0, 4, 0, 0, 0, 0); cyc(); check("keep_wash", 0, 0, 0, 5'b00000, 1, 1);
        drive(0, 5, 0, 0, 0, 0); cyc(); check("keep_rinse", 0, 0, 0, 5'b00000, 2, 1);
        drive(0, 6, 0, 0, 0, 0); cyc(); check("keep_spin", 0, 0, 1, 5'b10000, 0, 0);
        drive(0, 0, 0, 0, 0, 0); cyc(); check("keep_idle", 0, 0, 0, 5'b00000, 0, 0);

        // Reset mid-fill aborts; timing restarts from 1 after release.
        drive(0, 2, 0, 0, 0, 0); cyc(); check("rst_pre", 0, 0, 0, 5'b00000, 2, 1);
        drive(1, 2, 0, 0, 0, 0); cyc(); check("rst_on", 0, 0, 0, 5'b00000, 0, 0);
        drive(0, 2, 0, 0, 0, 0); cyc(); check("rst_e1", 0, 0, 0, 5'b00000, 2, 1);
        cyc();                          check("rst_e2", 0, 0, 0, 5'b00000, 1, 1);
        cyc();                          check("rst_e3", 1, 0, 0, 5'b00001, 0, 0);

        // Load to the finished phase and pause in DONE keep the level up.
        drive(0, 2, 0, 1, 0, 9); cyc(); check("dn_load", 1, 0, 0, 5'b00000, 0, 0);
        drive(0, 2, 1, 0, 0, 0); cyc(); check("dn_pause", 1, 0, 0, 5'b00000, 0, 0);

        // Reset restores defaults and beats a simultaneous load.
        drive(1, 2, 0, 1, 0, 7); cyc(); check("rst_ld", 0, 0, 0, 5'b00000, 0, 0);
        drive(0, 2, 0, 0, 0, 0); cyc(); check("dflt_fill", 0, 0, 0, 5'b00000, 2, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
